// File: rtl/parking_lot_ctrl.sv
// -----------------------------------------------------------------------------
// parking_lot_ctrl
//
// Occupancy controller for a car park with LANES independent entry/exit lanes.
// Each lane has two light beams, a (outer) and b (inner). A vehicle driving in
// blocks a, then both, then only b, then neither. A vehicle driving out does
// the same in mirror order. A per-lane FSM follows that pattern and pulses
// enter/exit when a complete pass is seen. The pulses from all lanes are then
// netted into a saturating occupancy count, which also has sticky
// overflow/underflow flags.
//
// Optional feature: define PARKING_DEBOUNCE_EN to place a 2-flop synchronizer
// and a DEB_CYCLES stability filter in front of each lane FSM. When it is
// undefined, ab must be synchronous to clk and drives the FSMs directly.
//
// Parameters:
//   LANES      number of lanes (1..8)
//   CAPACITY   maximum occupancy (1..255)
//   CNT_W      count width, at least clog2(CAPACITY+1)
//   DEB_CYCLES debounce stability length (1..15), used only with the filter
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   ab         lane sensors, lane i: a = ab[2i+1], b = ab[2i], 1 = blocked
//   clr_err    synchronous clear of err_ovf / err_unf
//   enter      one-cycle vehicle-entered pulse per lane
//   exit       one-cycle vehicle-exited pulse per lane
//   count      current occupancy
//   full       count == CAPACITY
//   empty      count == 0
//   err_ovf    sticky: an update tried to go above CAPACITY
//   err_unf    sticky: an update tried to go below 0
// -----------------------------------------------------------------------------
module parking_lot_ctrl #(
  parameter int LANES      = 2,
  parameter int CAPACITY   = 16,
  parameter int CNT_W      = 5,
  parameter int DEB_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2*LANES-1:0] ab,
  input  logic               clr_err,
  output logic [LANES-1:0]   enter,
  output logic [LANES-1:0]   exit,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               err_ovf,
  output logic               err_unf
);

  // Elaboration-time guard against unsupported parameter combinations.
  if (LANES < 1 || LANES > 8 || CAPACITY < 1 || CAPACITY > 255 ||
      DEB_CYCLES < 1 || DEB_CYCLES > 15 || (1 << CNT_W) <= CAPACITY) begin : g_param_check
    $error("parking_lot_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A1     = 3'd1,  // outer beam only: possibly entering
    B1     = 3'd2,  // inner beam only: possibly leaving
    IN_AB  = 3'd3,
    OUT_AB = 3'd4,
    IN_B   = 3'd5,
    OUT_A  = 3'd6
  } lane_state_t;

  lane_state_t state [LANES];
  logic [1:0]  sens  [LANES];  // {a,b} as seen by each lane FSM

  // ---------------------------------------------------------------------------
  // Sensor conditioning
  // ---------------------------------------------------------------------------
`ifdef PARKING_DEBOUNCE_EN
  logic [1:0] sync1 [LANES];
  logic [1:0] sync2 [LANES];
  logic [1:0] last  [LANES];  // previous synchronized sample
  logic [1:0] filt  [LANES];  // value forwarded to the FSM
  logic [3:0] run   [LANES];  // length of the current run of identical samples
  logic [3:0] run_nxt [LANES];

  // NOTE: every variable written in always_comb is given a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      run_nxt[i] = 4'd1;
      if (sync2[i] == last[i]) run_nxt[i] = (run[i] == 4'd15) ? run[i] : run[i] + 4'd1;
    end
  end

  // NOTE: these per-lane arrays are a handful of flops, not a RAM, so they are
  // reset along with the rest of the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) begin
        sync1[i] <= 2'b00;
        sync2[i] <= 2'b00;
        last[i]  <= 2'b00;
        filt[i]  <= 2'b00;
        run[i]   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        sync1[i] <= ab[2*i +: 2];
        sync2[i] <= sync1[i];
        last[i]  <= sync2[i];
        run[i]   <= run_nxt[i];
        if (run_nxt[i] >= 4'(DEB_CYCLES)) filt[i] <= sync2[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) sens[i] = filt[i];
  end
`else
  always_comb begin
    for (int i = 0; i < LANES; i++) sens[i] = ab[2*i +: 2];
  end
`endif

  // ---------------------------------------------------------------------------
  // Lane FSMs. Patterns not listed for a state hold that state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) state[i] <= IDLE;
      enter <= '0;
      exit  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        enter[i] <= 1'b0;
        exit[i]  <= 1'b0;
        case (state[i])
          IDLE:   if (sens[i] == 2'b10) state[i] <= A1;
                  else if (sens[i] == 2'b01) state[i] <= B1;
          A1:     if (sens[i] == 2'b11) state[i] <= IN_AB;
                  else if (sens[i] == 2'b00) state[i] <= IDLE;
          B1:     if (sens[i] == 2'b11) state[i] <= OUT_AB;
                  else if (sens[i] == 2'b00) state[i] <= IDLE;
          IN_AB:  if (sens[i] == 2'b01) state[i] <= IN_B;
                  else if (sens[i] == 2'b10) state[i] <= A1;
          OUT_AB: if (sens[i] == 2'b10) state[i] <= OUT_A;
                  else if (sens[i] == 2'b01) state[i] <= B1;
          IN_B:   if (sens[i] == 2'b00) begin
                    state[i] <= IDLE;
                    enter[i] <= 1'b1;
                  end else if (sens[i] == 2'b11) state[i] <= IN_AB;
          OUT_A:  if (sens[i] == 2'b00) begin
                    state[i] <= IDLE;
                    exit[i]  <= 1'b1;
                  end else if (sens[i] == 2'b11) state[i] <= OUT_AB;
          default: state[i] <= IDLE;  // unused encoding: recover silently
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy: one netted update per cycle from the registered pulses.
  // ---------------------------------------------------------------------------
  localparam int NW = ((CNT_W > 4) ? CNT_W : 4) + 2;  // room for sign and carry
  localparam logic signed [NW-1:0] CAP_S = NW'(CAPACITY);

  logic [3:0]           n_ent;
  logic [3:0]           n_ext;
  logic signed [NW-1:0] net;
  logic                 ovf;
  logic                 unf;

  always_comb begin
    n_ent = 4'd0;
    n_ext = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      n_ent = n_ent + 4'(enter[i]);
      n_ext = n_ext + 4'(exit[i]);
    end
    net = NW'(count) + NW'(n_ent) - NW'(n_ext);
    unf = net[NW-1];
    ovf = !unf && (net > CAP_S);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (ovf)      count <= CNT_W'(CAPACITY);
      else if (unf) count <= '0;
      else          count <= net[CNT_W-1:0];
      // A fresh error wins over a simultaneous clear.
      err_ovf <= ovf || (err_ovf && !clr_err);
      err_unf <= unf || (err_unf && !clr_err);
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
module tb_parking_lot_ctrl;

  localparam int LANES      = 2;
  localparam int CAPACITY   = 16;
  localparam int CNT_W      = 5;
  localparam int DEB_CYCLES = 3;

  logic               clk     = 1'b0;
  logic               reset_n = 1'b0;
  logic [2*LANES-1:0] ab      = '0;
  logic               clr_err = 1'b0;
  logic [LANES-1:0]   enter;
  logic [LANES-1:0]   exit_o;
  logic [CNT_W-1:0]   count;
  logic               full, empty, err_ovf, err_unf;

  parking_lot_ctrl #(
    .LANES(LANES), .CAPACITY(CAPACITY), .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ab(ab), .clr_err(clr_err),
    .enter(enter), .exit(exit_o), .count(count), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. A lane is a position along a fixed beam pattern:
  // entering walks 00,10,11,01,00; leaving walks the a/b mirror of it.
  // Matching the next pattern advances, matching the previous one retreats,
  // anything else is ignored. Reaching the far end counts the vehicle.
  // ---------------------------------------------------------------------------
  int               m_dir [LANES];  // +1 entering, -1 leaving, 0 idle
  int               m_pos [LANES];
  logic [LANES-1:0] m_ent, m_ext;
  int               m_cnt;
  logic             m_ovf, m_unf;

  function automatic logic [1:0] path(input int dir, input int pos);
    logic [1:0] p;
    case (pos)
      1:       p = 2'b10;
      2:       p = 2'b11;
      3:       p = 2'b01;
      default: p = 2'b00;
    endcase
    if (dir < 0) p = {p[0], p[1]};
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_dir[i] = 0;
      m_pos[i] = 0;
    end
    m_ent = '0; m_ext = '0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_edge();
    int         net;
    logic [1:0] s;
    net = m_cnt + $countones(m_ent) - $countones(m_ext);
    if (clr_err) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (net > CAPACITY) begin m_cnt = CAPACITY; m_ovf = 1'b1; end
    else if (net < 0)   begin m_cnt = 0;        m_unf = 1'b1; end
    else m_cnt = net;
    for (int i = 0; i < LANES; i++) begin
      s = ab[2*i +: 2];
      m_ent[i] = 1'b0;
      m_ext[i] = 1'b0;
      if (m_dir[i] == 0) begin
        if (s == 2'b10)      begin m_dir[i] = 1;  m_pos[i] = 1; end
        else if (s == 2'b01) begin m_dir[i] = -1; m_pos[i] = 1; end
      end else if (s == path(m_dir[i], m_pos[i] + 1)) begin
        m_pos[i]++;
        if (m_pos[i] == 4) begin
          if (m_dir[i] > 0) m_ent[i] = 1'b1; else m_ext[i] = 1'b1;
          m_dir[i] = 0;
          m_pos[i] = 0;
        end
      end else if (s == path(m_dir[i], m_pos[i] - 1)) begin
        m_pos[i]--;
        if (m_pos[i] == 0) m_dir[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("enter",   enter,   m_ent);
    check("exit",    exit_o,  m_ext);
    check("count",   count,   m_cnt);
    check("full",    full,    m_cnt == CAPACITY);
    check("empty",   empty,   m_cnt == 0);
    check("err_ovf", err_ovf, m_ovf);
    check("err_unf", err_unf, m_unf);
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cyc(input logic [2*LANES-1:0] v, input logic c);
    ab = v;
    clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic lane_seq(input int lane, input logic [1:0] p0, input logic [1:0] p1,
                          input logic [1:0] p2, input logic [1:0] p3);
    logic [2*LANES-1:0] v;
    v = '0; v[2*lane +: 2] = p0; cyc(v, 1'b0);
    v = '0; v[2*lane +: 2] = p1; cyc(v, 1'b0);
    v = '0; v[2*lane +: 2] = p2; cyc(v, 1'b0);
    v = '0; v[2*lane +: 2] = p3; cyc(v, 1'b0);
  endtask

  // Called just after an edge; asserts reset between edges and checks the
  // asynchronous clear before any further edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    #2 reset_n = 1'b1;
  endtask

  // Random stimulus: each lane walks a beam pattern with occasional retreats,
  // pauses and junk values.
  int g_dir [LANES];
  int g_pos [LANES];

  task automatic rand_cyc(input int bias_in);
    logic [2*LANES-1:0] v;
    int r;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (g_dir[i] == 0) begin
        g_dir[i] = ($urandom_range(99) < bias_in) ? 1 : -1;
        g_pos[i] = 0;
      end
      r = $urandom_range(99);
      if (r < 55) g_pos[i]++;
      else if (r < 70 && g_pos[i] > 0) g_pos[i]--;
      if (r >= 96) v[2*i +: 2] = 2'($urandom_range(3));
      else         v[2*i +: 2] = path(g_dir[i], g_pos[i]);
      if (g_pos[i] >= 4) begin g_pos[i] = 0; g_dir[i] = 0; end
    end
    cyc(v, $urandom_range(99) < 3);
  endtask

  task automatic tick(input logic [2*LANES-1:0] v);
    ab = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < LANES; i++) begin g_dir[i] = 0; g_pos[i] = 0; end
    model_reset();
    #3;
    check("reset count", count, 0);
    check("reset empty", empty, 1);
    check("reset full",  full,  0);
    compare_all();
    #5 reset_n = 1'b1;  // released at t=8, away from the edge at t=15

`ifndef PARKING_DEBOUNCE_EN
    // Entry on lane 0.
    lane_seq(0, 2'b10, 2'b11, 2'b01, 2'b00);
    check("entry pulse", enter, 2'b01);
    check("entry count before update", count, 0);
    cyc('0, 1'b0);
    check("entry count", count, 1);
    check("entry empty", empty, 0);
    check("entry pulse width", enter, 2'b00);

    // Two more entries, then an exit on lane 1 from count 3.
    lane_seq(0, 2'b10, 2'b11, 2'b01, 2'b00);
    lane_seq(0, 2'b10, 2'b11, 2'b01, 2'b00);
    cyc('0, 1'b0);
    check("count three", count, 3);
    lane_seq(1, 2'b01, 2'b11, 2'b10, 2'b00);
    check("exit pulse", exit_o, 2'b10);
    cyc('0, 1'b0);
    check("exit count", count, 2);

    // Aborted entry: backs out after both beams.
    lane_seq(0, 2'b10, 2'b11, 2'b10, 2'b00);
    check("abort no pulse", enter, 2'b00);
    cyc('0, 1'b0);
    check("abort count", count, 2);

    // Fill to 15, then two simultaneous entries overflow.
    for (int k = 0; k < 13; k++) lane_seq(0, 2'b10, 2'b11, 2'b01, 2'b00);
    cyc('0, 1'b0);
    check("count fifteen", count, 15);
    cyc(4'b1010, 1'b0);
    cyc(4'b1111, 1'b0);
    cyc(4'b0101, 1'b0);
    cyc(4'b0000, 1'b0);
    check("dual entry pulses", enter, 2'b11);
    cyc('0, 1'b0);
    check("ovf count", count, CAPACITY);
    check("ovf full", full, 1);
    check("ovf flag", err_ovf, 1);
    // Entry is still detected while full.
    lane_seq(1, 2'b10, 2'b11, 2'b01, 2'b00);
    check("entry while full", enter, 2'b10);
    cyc('0, 1'b1);
    check("ovf set beats clr", err_ovf, 1);
    cyc('0, 1'b1);
    check("ovf cleared", err_ovf, 0);
    check("count after clr", count, CAPACITY);

    // Underflow from empty, including an error coinciding with clr_err.
    do_reset();
    lane_seq(0, 2'b01, 2'b11, 2'b10, 2'b00);
    check("unf exit pulse", exit_o, 2'b01);
    cyc('0, 1'b0);
    check("unf count", count, 0);
    check("unf flag", err_unf, 1);
    lane_seq(0, 2'b01, 2'b11, 2'b10, 2'b00);
    cyc('0, 1'b1);
    check("unf set beats clr", err_unf, 1);
    cyc('0, 1'b1);
    check("unf cleared", err_unf, 0);

    // Reset while lane 0 sits in the last step of an entry.
    lane_seq(0, 2'b10, 2'b11, 2'b01, 2'b01);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    check("pre-reset count", count, 1);
    lane_seq(0, 2'b10, 2'b11, 2'b01, 2'b01);
    do_reset();
    check("mid reset count", count, 0);
    check("mid reset empty", empty, 1);
    cyc('0, 1'b0);
    check("no pulse after reset", enter, 2'b00);
    cyc('0, 1'b0);
    check("count after reset", count, 0);

    // Randomized traffic: entry-heavy, exit-heavy, then mixed.
    for (int k = 0; k < 600; k++) rand_cyc(85);
    for (int k = 0; k < 600; k++) rand_cyc(15);
    do_reset();
    for (int k = 0; k < 500; k++) rand_cyc(50);
`else
    // Two-cycle glitch of 10 on lane 0 is filtered out.
    tick(4'b0010);
    tick(4'b0010);
    for (int k = 0; k < 8; k++) begin
      tick(4'b0000);
      check("glitch no pulse", enter, 0);
    end
    check("glitch count", count, 0);

    // Full entry with every value held four cycles.
    for (int k = 0; k < 4; k++) begin tick(4'b0010); check("deb seq 10", enter, 0); end
    for (int k = 0; k < 4; k++) begin tick(4'b0011); check("deb seq 11", enter, 0); end
    for (int k = 0; k < 4; k++) begin tick(4'b0001); check("deb seq 01", enter, 0); end
    for (int k = 0; k < 8; k++) begin
      tick(4'b0000);
      check("deb enter timing", enter, (k == 5) ? 32'd1 : 32'd0);
    end
    check("deb count", count, 1);
    check("deb empty", empty, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_lot_ctrl.md
PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

Interface
REQ-001 The block SHALL have parameter LANES, default 2, giving the number of independent entry/exit lanes (1..8).
REQ-002 The block SHALL have parameter CAPACITY, default 16, giving the maximum occupancy (1..255).
REQ-003 The block SHALL have parameter CNT_W, default 5, giving the count width, which SHALL be at least clog2(CAPACITY+1).
REQ-004 The block SHALL have parameter DEB_CYCLES, default 3, giving the debounce stability length in cycles (1..15), used only when PARKING_DEBOUNCE_EN is defined.
REQ-005 Port clk SHALL be an input, 1 bit, the single clock; all flops SHALL be rising-edge.
REQ-006 Port reset_n SHALL be an input, 1 bit, the reset, which is asynchronous and active-low.
REQ-007 Port ab SHALL be an input, 2*LANES bits, carrying the lane sensors: lane i a=ab[2i+1], b=ab[2i], where 1 means beam blocked.
REQ-008 Port clr_err SHALL be an input, 1 bit, a synchronous clear of the sticky error flags.
REQ-009 Port enter SHALL be an output, LANES bits, giving a one-cycle vehicle-entered pulse per lane.
REQ-010 Port exit SHALL be an output, LANES bits, giving a one-cycle vehicle-exited pulse per lane.
REQ-011 Port count SHALL be an output, CNT_W bits, giving the current occupancy.
REQ-012 Ports full and empty SHALL be outputs, 1 bit each: full = (count==CAPACITY), empty = (count==0).
REQ-013 Ports err_ovf and err_unf SHALL be outputs, 1 bit each, acting as sticky overflow and underflow flags.

Function
REQ-014 Each lane SHALL run its own 7-state FSM (IDLE, A1, B1, IN_AB, OUT_AB, IN_B, OUT_A) on its sampled {a,b}; any {a,b} not listed below SHALL hold the current state.
REQ-015 Lane FSM transitions out of IDLE and its first two states SHALL be:
- IDLE: 10 goes to A1; 01 goes to B1.
- A1: 11 goes to IN_AB; 00 goes to IDLE.
- B1: 11 goes to OUT_AB; 00 goes to IDLE.
REQ-016 Lane FSM transitions out of the remaining states SHALL be:
- IN_AB: 01 goes to IN_B; 10 goes to A1.
- OUT_AB: 10 goes to OUT_A; 01 goes to B1.
- IN_B: 00 goes to IDLE and fires entry; 11 goes to IN_AB.
- OUT_A: 00 goes to IDLE and fires exit; 11 goes to OUT_AB.
REQ-017 enter[i] and exit[i] SHALL be registered and asserted for exactly the one cycle following the clock edge at which the firing transition is taken.
REQ-018 At the edge after a pulse, count SHALL update to count + popcount(enter) - popcount(exit), so simultaneous entries and exits on different lanes net together in one update.
REQ-019 If the net result would exceed CAPACITY, count SHALL saturate at CAPACITY and err_ovf SHALL set on the same edge.
REQ-020 If the net result would go below 0, count SHALL saturate at 0 and err_unf SHALL set on the same edge.
REQ-021 The lane FSMs SHALL keep tracking and pulsing while full; full SHALL NOT block entry detection.
REQ-022 err_ovf and err_unf SHALL remain set until a cycle with clr_err=1; if a new error occurs in the same cycle as clr_err, the flag SHALL set rather than clear.
REQ-023 Illegal lane state encodings SHALL return to IDLE on the next edge without producing a pulse.

Reset
REQ-024 While reset_n=0, asynchronously: all lane FSMs SHALL be IDLE, enter=0, exit=0, count=0, empty=1, full=0, err_ovf=0, err_unf=0, and debounce state SHALL be cleared to 00.
REQ-025 A reset asserted mid-sequence SHALL abandon the sequence with no pulse; occupancy SHALL NOT be restored.
REQ-026 After reset_n rises, the first active edge SHALL behave as a normal edge.

Configuration
REQ-027 With macro PARKING_DEBOUNCE_EN defined, each lane's {a,b} SHALL pass through a 2-flop synchronizer and then a filter.
REQ-028 The filter SHALL forward a new value only after DEB_CYCLES consecutive identical synchronized samples, giving a sensor-to-FSM latency of 2+DEB_CYCLES cycles; shorter glitches SHALL be ignored.
REQ-029 Without PARKING_DEBOUNCE_EN, ab SHALL feed the FSMs directly with zero added latency, and ab is required to be synchronous to clk.

Verification
REQ-030 Entry, lane 0, no debounce: ab0 = 10, 11, 01, 00, each held one cycle -> enter[0] high exactly one cycle, then count 0 to 1 and empty drops.
REQ-031 Exit, lane 1, with count=3: ab1 = 01, 11, 10, 00 -> exit[1] single pulse, count becomes 2.
REQ-032 Aborted entry: ab0 = 10, 11, 10, 00 -> no pulse and count unchanged.
REQ-033 Simultaneous events and overflow: count=15, CAPACITY=16, lanes 0 and 1 both complete entry on the same edge -> count=16, full=1, err_ovf=1; a later clr_err clears err_ovf while count stays 16.
REQ-034 Underflow and mid-sequence reset: exit at count=0 -> count stays 0 and err_unf=1; then reset_n pulsed low while a lane is in IN_B -> all outputs return to reset values and no pulse follows.
REQ-035 Debounce with PARKING_DEBOUNCE_EN and DEB_CYCLES=3: a 2-cycle glitch of 10 is ignored, while a full entry sequence with each value held 4 cycles yields one enter pulse 5 cycles after the final 00 is applied.
